truth_table_checker: RTL and testbench

//  Self-timed response checker for small combinational gate networks (AND/OR/NOT builds).

---
 rtl/truth_table_checker.sv | 116 +++++++++++
 tb/tb_truth_table_checker.sv | 122 ++++++++++++
 2 files changed

// File: rtl/truth_table_checker.sv
// truth_table_checker
//   Drives every input vector 0 .. 2**N_IN-1 into a small combinational
//   network. After a settle window it samples the network output, then
//   compares the captured truth table against EXPECTED. The result is a
//   registered pass/fail flag, an error count and the index of the first
//   vector that mismatched.
// Ports
//   clk, rst_n        clock (rising edge), async active-low reset
//   start             run request, honoured only in IDLE or DONE
//   dut_in            network output under test
//   vec_out           vector driven to the network, {A,B,C} for N_IN=3
//   busy              run in progress
//   done              results valid
//   pass              captured == EXPECTED (qualified by done)
//   err_count         number of mismatching vectors
//   captured          bit i = dut_in sampled for vector i
//   first_fail_valid  at least one mismatch recorded
//   first_fail_idx    lowest mismatching vector index
module truth_table_checker #(
  parameter int                  N_IN     = 3,
  parameter int                  SETTLE   = 1,
  parameter logic [2**N_IN-1:0]  EXPECTED = 8'h7F
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                dut_in,
  output logic [N_IN-1:0]     vec_out,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N_IN:0]       err_count,
  output logic [2**N_IN-1:0]  captured,
  output logic                first_fail_valid,
  output logic [N_IN-1:0]     first_fail_idx
);
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(2**N_IN - 1);

  typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic           accept;
  logic           mismatch;
  logic           last_vec;
  logic [N_IN:0]  err_nxt;

  // vec_out is the vector index register itself, so the network sees a
  // registered, glitch-free vector.
  assign last_vec = (vec_out == LAST_IDX);
  assign mismatch = (dut_in != EXPECTED[vec_out]);
  // The count including the current sample. pass uses it so the last
  // vector's mismatch is reflected in the same cycle that done rises.
  assign err_nxt  = err_count + (N_IN+1)'(mismatch);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE, DONE: if (start) begin
        accept    = 1'b1;
        state_nxt = WAIT;
      end
      WAIT:    if (cnt == CW'(SETTLE-1)) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = last_vec ? DONE : WAIT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      cnt              <= '0;
      vec_out          <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      captured         <= '0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt              <= '0;
        vec_out          <= '0;
        busy             <= 1'b1;
        done             <= 1'b0;
        pass             <= 1'b0;
        err_count        <= '0;
        captured         <= '0;
        first_fail_valid <= 1'b0;
        first_fail_idx   <= '0;
      end else if (state == WAIT) begin
        cnt <= cnt + 1'b1;
      end else if (state == SAMPLE) begin
        captured[vec_out] <= dut_in;
        err_count         <= err_nxt;
        if (mismatch && !first_fail_valid) begin
          first_fail_valid <= 1'b1;
          first_fail_idx   <= vec_out;
        end
        if (last_vec) begin
          busy <= 1'b0;
          done <= 1'b1;
          pass <= (err_nxt == '0);
        end else begin
          vec_out <= vec_out + 1'b1;
          cnt     <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker with default parameters.
// The stimulus net is chosen by mode: 0 golden ~(A&B)|(A&B&~C),
// 1 tied high, 2 tied low.
module tb_truth_table_checker;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       dut_in;
  logic [2:0] vec_out;
  logic       busy, done, pass;
  logic [3:0] err_count;
  logic [7:0] captured;
  logic       first_fail_valid;
  logic [2:0] first_fail_idx;
  int         mode = 0;
  int         n_run = 0;
  int         n_fail = 0;

  truth_table_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_in(dut_in),
    .vec_out(vec_out), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .captured(captured),
    .first_fail_valid(first_fail_valid), .first_fail_idx(first_fail_idx)
  );

  always #5 clk = ~clk;

  wire a = vec_out[2], b = vec_out[1], c = vec_out[0];
  always_comb begin
    case (mode)
      1:       dut_in = 1'b1;
      2:       dut_in = 1'b0;
      default: dut_in = ~(a & b) | (a & b & ~c);
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_vec"},  32'(vec_out), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_pass"}, 32'(pass), 0);
    chk({tag, "_err"},  32'(err_count), 0);
    chk({tag, "_cap"},  32'(captured), 0);
    chk({tag, "_ffv"},  32'(first_fail_valid), 0);
    chk({tag, "_ffi"},  32'(first_fail_idx), 0);
  endtask

  // One full run: start pulse, per-cycle vec_out/done trace, then results.
  // With repulse set, start is raised again in cycles 3 and 9 of the run.
  task automatic run(input string tag, input int m, input logic [7:0] ecap,
                     input logic [3:0] eerr, input logic effv, input logic [2:0] effi,
                     input logic epass, input bit repulse);
    mode = m;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk({tag, "_acc_busy"}, 32'(busy), 1);
    chk({tag, "_acc_cap"},  32'(captured), 0);
    chk({tag, "_acc_err"},  32'(err_count), 0);
    chk({tag, "_acc_ffv"},  32'(first_fail_valid), 0);
    for (int k = 0; k < 16; k++) begin
      chk({tag, "_vec"},  32'(vec_out), 32'(k / 2));
      chk({tag, "_busy"}, 32'(busy), 1);
      chk({tag, "_early_done"}, 32'(done), 0);
      start = repulse && (k == 3 || k == 9);
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk({tag, "_done"},  32'(done), 1);
    chk({tag, "_idle"},  32'(busy), 0);
    chk({tag, "_cap"},   32'(captured), 32'(ecap));
    chk({tag, "_err"},   32'(err_count), 32'(eerr));
    chk({tag, "_ffv"},   32'(first_fail_valid), 32'(effv));
    if (effv) chk({tag, "_ffi"}, 32'(first_fail_idx), 32'(effi));
    chk({tag, "_pass"},  32'(pass), 32'(epass));
    chk({tag, "_lastvec"}, 32'(vec_out), 7);
    // Results hold in DONE.
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_hold_done"}, 32'(done), 1);
    chk({tag, "_hold_cap"},  32'(captured), 32'(ecap));
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 chk_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    run("golden",  0, 8'h7F, 4'd0, 1'b0, 3'd0, 1'b1, 1'b0);
    run("tie1",    1, 8'hFF, 4'd1, 1'b1, 3'd7, 1'b0, 1'b0);
    run("restart", 0, 8'h7F, 4'd0, 1'b0, 3'd0, 1'b1, 1'b0);
    run("tie0",    2, 8'h00, 4'd7, 1'b1, 3'd0, 1'b0, 1'b0);
    run("repulse", 0, 8'h7F, 4'd0, 1'b0, 3'd0, 1'b1, 1'b1);

    // Abort mid-run while vector 4 is on the bus.
    mode = 1;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("abort_vec", 32'(vec_out), 4);
    chk("abort_cap_pre", 32'(captured), 32'h0F);
    rst_n = 1'b0;
    #1 chk_zero("abort");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("abort_idle_busy", 32'(busy), 0);
    chk("abort_idle_vec", 32'(vec_out), 0);
    run("post_abort", 0, 8'h7F, 4'd0, 1'b0, 3'd0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
